// File: rtl/cmd_packet_receiver.sv
// Decodes host command packets (32-bit rx stream) into register writes and sync pulses; malformed packets are counted and dropped.
// Write/sync appear 1 cycle after the accepted beat; rx is stalled in PAYLOAD only while a held write waits for i_wr_rdy.
module cmd_packet_receiver #(
    parameter logic [15:0] MAGIC     = 16'hC0DE,
    parameter logic [7:0]  CMD_WRITE = 8'h01,
    parameter logic [7:0]  CMD_SYNC  = 8'h02,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      i_rx_data,
    input  logic             i_rx_vld,
    input  logic             i_rx_sop,
    input  logic             i_rx_eop,
    output logic             o_rx_rdy,
    output logic [15:0]      o_wr_addr,
    output logic [15:0]      o_wr_data,
    output logic             o_wr_vld,
    input  logic             i_wr_rdy,
    output logic             o_sync,
    output logic [CNT_W-1:0] o_pkt_ok_cnt,
    output logic [CNT_W-1:0] o_pkt_err_cnt,
    output logic             o_busy
);

    typedef struct packed {
        logic [15:0] magic;
        logic [7:0]  cmd;
        logic [7:0]  len;
    } hdr_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       remaining;
    logic [7:0]       remaining_nxt;
    wr_t              wr_q;
    logic             wr_vld_q;
    logic             sync_q;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;

    hdr_t             hdr;
    wr_t              beat_wr;
    logic             accept;
    logic             load;
    logic             sync_nxt;
    logic [1:0]       ok_inc;
    logic [1:0]       err_inc;
    logic             magic_ok;

    // An abort plus a bad header on the same beat is two error events, hence 2-bit increments.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, cnt} + {{CNT_W{1'b0}}, inc};
        if (sum[CNT_W+1:CNT_W] != 2'b00) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    assign hdr      = hdr_t'(i_rx_data);
    assign beat_wr  = wr_t'(i_rx_data);
    assign magic_ok = (hdr.magic == MAGIC);
    assign o_rx_rdy = (state == PAYLOAD) ? (!wr_vld_q || i_wr_rdy) : 1'b1;
    assign accept   = i_rx_vld && o_rx_rdy;

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        load          = 1'b0;
        sync_nxt      = 1'b0;
        ok_inc        = 2'd0;
        err_inc       = 2'd0;
        if (accept) begin
            if (i_rx_sop) begin
                if (state == PAYLOAD) begin
                    err_inc = 2'd1;
                end
                remaining_nxt = 8'd0;
                if (magic_ok && hdr.cmd == CMD_WRITE && hdr.len != 8'd0 && !i_rx_eop) begin
                    state_nxt     = PAYLOAD;
                    remaining_nxt = hdr.len;
                end else if (magic_ok && hdr.cmd == CMD_WRITE && hdr.len == 8'd0 && i_rx_eop) begin
                    ok_inc    = 2'd1;
                    state_nxt = IDLE;
                end else if (magic_ok && hdr.cmd == CMD_SYNC && hdr.len == 8'd0 && i_rx_eop) begin
                    ok_inc    = 2'd1;
                    sync_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    err_inc   = err_inc + 2'd1;
                    state_nxt = i_rx_eop ? IDLE : DROP;
                end
            end else begin
                case (state)
                    PAYLOAD: begin
                        load          = 1'b1;
                        remaining_nxt = remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            if (i_rx_eop) begin
                                ok_inc    = 2'd1;
                                state_nxt = IDLE;
                            end else begin
                                err_inc   = 2'd1;
                                state_nxt = DROP;
                            end
                        end else if (i_rx_eop) begin
                            err_inc       = 2'd1;
                            remaining_nxt = 8'd0;
                            state_nxt     = IDLE;
                        end
                    end
                    DROP: begin
                        if (i_rx_eop) begin
                            state_nxt = IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining <= 8'd0;
            wr_q      <= '0;
            wr_vld_q  <= 1'b0;
            sync_q    <= 1'b0;
            ok_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            remaining <= remaining_nxt;
            sync_q    <= sync_nxt;
            ok_cnt    <= sat_add(ok_cnt, ok_inc);
            err_cnt   <= sat_add(err_cnt, err_inc);
            // A load in the drain cycle replaces the consumed write, so the valid stays up.
            if (load) begin
                wr_q     <= beat_wr;
                wr_vld_q <= 1'b1;
            end else if (i_wr_rdy) begin
                wr_vld_q <= 1'b0;
            end
        end
    end

    assign o_wr_addr     = wr_q.addr;
    assign o_wr_data     = wr_q.data;
    assign o_wr_vld      = wr_vld_q;
    assign o_sync        = sync_q;
    assign o_pkt_ok_cnt  = ok_cnt;
    assign o_pkt_err_cnt = err_cnt;
    assign o_busy        = (state != IDLE) || wr_vld_q;

endmodule

// File: tb/tb_cmd_packet_receiver.sv
// Directed packet bench for cmd_packet_receiver: packet-level model compared every cycle, plus literal per-test expectations.
module tb_cmd_packet_receiver;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      rx_data = '0;
    logic             rx_vld = 1'b0;
    logic             rx_sop = 1'b0;
    logic             rx_eop = 1'b0;
    logic             rx_rdy;
    logic [15:0]      wr_addr;
    logic [15:0]      wr_data;
    logic             wr_vld;
    logic             wr_rdy = 1'b1;
    logic             sync;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;

    int checks = 0;
    int errors = 0;

    cmd_packet_receiver #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_vld     (rx_vld),
        .i_rx_sop     (rx_sop),
        .i_rx_eop     (rx_eop),
        .o_rx_rdy     (rx_rdy),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_wr_vld     (wr_vld),
        .i_wr_rdy     (wr_rdy),
        .o_sync       (sync),
        .o_pkt_ok_cnt (ok_cnt),
        .o_pkt_err_cnt(err_cnt),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // Packet-level reference: words still owed by the current WRITE, whether we are skipping to eop,
    // and the one write the consumer has not yet taken.
    int          m_rem = 0;
    bit          m_drop = 1'b0;
    bit          m_pend = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_data = '0;
    bit          m_sync = 1'b0;
    int          m_ok = 0;
    int          m_err = 0;
    bit          exp_rdy;
    bit          acc;
    bit          ld;
    logic [15:0] f_magic;
    logic [7:0]  f_cmd;
    int          f_len;

    logic [31:0] got_q[$];
    int          sync_seen = 0;

    always @(negedge clk) begin
        exp_rdy = (m_rem > 0) ? (!m_pend || wr_rdy) : 1'b1;
        chk("rx_rdy", {31'd0, rx_rdy}, {31'd0, exp_rdy});
        chk("wr_vld", {31'd0, wr_vld}, {31'd0, m_pend});
        if (m_pend) begin
            chk("wr_addr", {16'd0, wr_addr}, {16'd0, m_addr});
            chk("wr_data", {16'd0, wr_data}, {16'd0, m_data});
        end
        chk("sync", {31'd0, sync}, {31'd0, m_sync});
        chk("ok_cnt", 32'(ok_cnt), m_ok);
        chk("err_cnt", 32'(err_cnt), m_err);
        chk("busy", {31'd0, busy}, {31'd0, (m_rem > 0) || m_drop || m_pend});
        if (wr_vld && wr_rdy) got_q.push_back({wr_addr, wr_data});
        if (sync) sync_seen++;

        if (!rst_n) begin
            m_rem = 0; m_drop = 0; m_pend = 0; m_addr = '0; m_data = '0;
            m_sync = 0; m_ok = 0; m_err = 0;
        end else begin
            acc    = rx_vld && exp_rdy;
            ld     = 1'b0;
            m_sync = 1'b0;
            if (acc && rx_sop) begin
                if (m_rem > 0) m_err = sat(m_err + 1);
                m_rem   = 0;
                m_drop  = 0;
                f_magic = rx_data[31:16];
                f_cmd   = rx_data[15:8];
                f_len   = int'(rx_data[7:0]);
                if (f_magic == 16'hC0DE && f_cmd == 8'h01 && f_len > 0 && !rx_eop) begin
                    m_rem = f_len;
                end else if (f_magic == 16'hC0DE && f_len == 0 && rx_eop && (f_cmd == 8'h01 || f_cmd == 8'h02)) begin
                    m_ok   = sat(m_ok + 1);
                    m_sync = (f_cmd == 8'h02);
                end else begin
                    m_err  = sat(m_err + 1);
                    m_drop = !rx_eop;
                end
            end else if (acc && m_rem > 0) begin
                ld    = 1'b1;
                m_rem = m_rem - 1;
                if (rx_eop) begin
                    if (m_rem == 0) m_ok = sat(m_ok + 1);
                    else m_err = sat(m_err + 1);
                    m_rem = 0;
                end else if (m_rem == 0) begin
                    m_err  = sat(m_err + 1);
                    m_drop = 1'b1;
                end
            end else if (acc && m_drop && rx_eop) begin
                m_drop = 1'b0;
            end
            if (ld) begin
                m_pend = 1'b1;
                m_addr = rx_data[31:16];
                m_data = rx_data[15:0];
            end else if (wr_rdy) begin
                m_pend = 1'b0;
            end
        end
    end

    task automatic beat(input logic [31:0] d, input logic s, input logic e);
        int  n;
        bit  ok;
        n = 0;
        rx_data = d; rx_sop = s; rx_eop = e; rx_vld = 1'b1;
        do begin
            @(negedge clk);
            ok = rx_rdy;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: got not accepted after %0d cycles expected accepted", n);
        end
        rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        got_q.delete();
        sync_seen = 0;
    endtask

    task automatic chk_write(input int idx, input logic [31:0] exp);
        if (idx < got_q.size()) chk($sformatf("write%0d", idx), got_q[idx], exp);
    endtask

    task automatic chk_counts(input string tag, input int nwr, input int ok, input int err);
        chk({tag, "_nwrites"}, got_q.size(), nwr);
        chk({tag, "_ok"}, 32'(ok_cnt), ok);
        chk({tag, "_err"}, 32'(err_cnt), err);
    endtask

    initial begin
        idle(2);
        rst_n = 1'b1;
        chk("reset_rdy", {31'd0, rx_rdy}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // 1: WRITE N=2, consumer always ready
        do_reset();
        beat(32'hC0DE_0102, 1, 0);
        beat(32'h0010_ABCD, 0, 0);
        beat(32'h0011_1234, 0, 1);
        idle(3);
        chk_counts("t1", 2, 1, 0);
        chk_write(0, 32'h0010_ABCD);
        chk_write(1, 32'h0011_1234);

        // 2: same packet, consumer stalls while the first write is held
        do_reset();
        wr_rdy = 1'b0;
        beat(32'hC0DE_0102, 1, 0);
        beat(32'h0010_ABCD, 0, 0);
        fork
            begin
                idle(5);
                wr_rdy = 1'b1;
            end
        join_none
        beat(32'h0011_1234, 0, 1);
        idle(3);
        chk_counts("t2", 2, 1, 0);
        chk_write(0, 32'h0010_ABCD);
        chk_write(1, 32'h0011_1234);

        // 3: three back-to-back SYNC packets
        do_reset();
        for (int i = 0; i < 3; i++) beat(32'hC0DE_0200, 1, 1);
        idle(3);
        chk_counts("t3", 0, 3, 0);
        chk("t3_pulses", sync_seen, 3);

        // 4: bad magic, tail dropped up to eop
        do_reset();
        beat(32'hBEEF_0101, 1, 0);
        beat(32'h0001_0001, 0, 0);
        beat(32'h0002_0002, 0, 0);
        beat(32'h0003_0003, 0, 1);
        idle(2);
        chk_counts("t4", 0, 0, 1);
        chk("t4_busy", {31'd0, busy}, 32'd0);

        // 5a: WRITE N=3 cut short after 2 words
        do_reset();
        beat(32'hC0DE_0103, 1, 0);
        beat(32'h0040_4444, 0, 0);
        beat(32'h0041_5555, 0, 1);
        idle(3);
        chk_counts("t5a", 2, 0, 1);
        chk_write(1, 32'h0041_5555);

        // 5b: WRITE N=1 with an extra payload word
        do_reset();
        beat(32'hC0DE_0101, 1, 0);
        beat(32'h0050_6666, 0, 0);
        beat(32'h0051_7777, 0, 1);
        idle(3);
        chk_counts("t5b", 1, 0, 1);
        chk_write(0, 32'h0050_6666);

        // 6: reset mid-payload, tail without sop is ignored, next packet decodes normally
        do_reset();
        beat(32'hC0DE_0103, 1, 0);
        beat(32'h0020_1111, 0, 0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        got_q.delete();
        chk("t6_wr_vld", {31'd0, wr_vld}, 32'd0);
        chk("t6_addr", {16'd0, wr_addr}, 32'd0);
        beat(32'h0021_2222, 0, 0);
        beat(32'h0022_3333, 0, 1);
        idle(2);
        chk_counts("t6_tail", 0, 0, 0);
        beat(32'hC0DE_0101, 1, 0);
        beat(32'h0030_5555, 0, 1);
        idle(3);
        chk_counts("t6", 1, 1, 0);
        chk_write(0, 32'h0030_5555);

        // 7: sop during payload aborts; abort plus bad header counts twice; WRITE N=0 is ok
        do_reset();
        beat(32'hC0DE_0102, 1, 0);
        beat(32'h0060_0001, 0, 0);
        beat(32'hC0DE_0200, 1, 1);
        beat(32'hC0DE_0102, 1, 0);
        beat(32'h0061_0002, 0, 0);
        beat(32'hBEEF_0200, 1, 1);
        beat(32'hC0DE_0100, 1, 1);
        idle(3);
        chk_counts("t7", 2, 2, 3);
        chk("t7_pulses", sync_seen, 1);

        // 8: counters saturate
        do_reset();
        for (int i = 0; i < 20; i++) beat(32'hC0DE_0200, 1, 1);
        for (int i = 0; i < 20; i++) beat(32'h1234_0200, 1, 1);
        idle(3);
        chk_counts("t8", 0, MAXC, MAXC);
        chk("t8_pulses", sync_seen, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
